// File: rtl/oled_frame_server_if.sv
`default_nettype none
// ============================================================================
// Module   : oled_frame_server_if
// Brief    : Driver read port plus game-side write/clear/swap controls.
// Revision : 1.0
// ============================================================================
interface oled_frame_server_if;
    logic        frame_begin;
    logic        sample_pixel;
    logic [12:0] pixel_index;
    logic [15:0] pixel_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [6:0]  wr_x;
    logic [5:0]  wr_y;
    logic [15:0] wr_colour;
    logic        clr_req;
    logic [15:0] clr_colour;
    logic        clr_busy;
    logic        swap_req;
    logic        swap_pending;
    logic        front_sel;
    logic        wr_oor;
    logic [7:0]  frame_count;

    modport master (
        output frame_begin, sample_pixel, pixel_index,
        output wr_valid, wr_x, wr_y, wr_colour,
        output clr_req, clr_colour, swap_req,
        input  pixel_data, wr_ready, clr_busy, swap_pending,
        input  front_sel, wr_oor, frame_count
    );

    modport slave (
        input  frame_begin, sample_pixel, pixel_index,
        input  wr_valid, wr_x, wr_y, wr_colour,
        input  clr_req, clr_colour, swap_req,
        output pixel_data, wr_ready, clr_busy, swap_pending,
        output front_sel, wr_oor, frame_count
    );
endinterface
`default_nettype wire

// File: rtl/oled_frame_server.sv
`default_nettype none
// ============================================================================
// Module   : oled_frame_server
// Brief    : Double-buffered RGB565 frame store; swaps only at frame_begin.
// Revision : 1.0
// ============================================================================
module oled_frame_server #(
    parameter int          WIDTH      = 96,
    parameter int          HEIGHT     = 64,
    parameter logic [15:0] OOR_COLOUR = 16'h0000
) (
    input  wire                  clk,
    input  wire                  reset,
    oled_frame_server_if.slave   bus
);

    localparam logic [12:0] c_DEPTH  = 13'(WIDTH * HEIGHT);
    localparam logic [12:0] c_LAST   = 13'(WIDTH * HEIGHT - 1);
    localparam logic [7:0]  c_WIDTH  = 8'(WIDTH);
    localparam logic [6:0]  c_HEIGHT = 7'(HEIGHT);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_CLEAR     = 2'd1;
    localparam logic [1:0] S_WAIT_SWAP = 2'd2;

    logic [15:0] r_mem0 [0:WIDTH*HEIGHT-1];
    logic [15:0] r_mem1 [0:WIDTH*HEIGHT-1];

    logic [1:0]  r_state, w_next_state;
    logic [12:0] r_clr_addr;
    logic [15:0] r_clr_colour;
    logic        r_swap_pending;
    logic        r_front_sel;
    logic [7:0]  r_frame_count;
    logic        r_wr_oor;
    logic [15:0] r_pixel_data;

    logic        w_clr_start, w_swap_set, w_apply;
    logic        w_wr_ready, w_wr_fire, w_wr_in_range;
    logic [12:0] w_wr_addr, w_waddr;
    logic [15:0] w_wdata;
    logic        w_we;
    logic        w_unused;

    assign w_unused      = &{1'b0, bus.sample_pixel};
    assign w_wr_ready    = (r_state != S_CLEAR) && !r_swap_pending;
    assign w_wr_fire     = bus.wr_valid && w_wr_ready;
    assign w_wr_in_range = ({1'b0, bus.wr_x} < c_WIDTH) && ({1'b0, bus.wr_y} < c_HEIGHT);
    assign w_wr_addr     = 13'(bus.wr_y) * 13'(WIDTH) + 13'(bus.wr_x);

    // The clear and pixel writes never overlap: wr_ready is low throughout CLEAR.
    assign w_we    = !reset && ((r_state == S_CLEAR) || (w_wr_fire && w_wr_in_range));
    assign w_waddr = (r_state == S_CLEAR) ? r_clr_addr : w_wr_addr;
    assign w_wdata = (r_state == S_CLEAR) ? r_clr_colour : bus.wr_colour;

    always_comb begin
        w_next_state = r_state;
        w_clr_start  = 1'b0;
        w_swap_set   = 1'b0;
        w_apply      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.clr_req) begin
                    w_next_state = S_CLEAR;
                    w_clr_start  = 1'b1;
                    w_swap_set   = bus.swap_req;
                end else if (bus.swap_req) begin
                    w_next_state = S_WAIT_SWAP;
                    w_swap_set   = 1'b1;
                end
            end
            S_CLEAR: begin
                w_swap_set = bus.swap_req;
                if (r_clr_addr == c_LAST) begin
                    w_next_state = (r_swap_pending || bus.swap_req) ? S_WAIT_SWAP : S_IDLE;
                end
            end
            S_WAIT_SWAP: begin
                if (bus.frame_begin) begin
                    w_apply      = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_clr_addr     <= '0;
            r_clr_colour   <= '0;
            r_swap_pending <= 1'b0;
            r_front_sel    <= 1'b0;
            r_frame_count  <= '0;
            r_wr_oor       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_clr_start) begin
                r_clr_addr   <= '0;
                r_clr_colour <= bus.clr_colour;
            end else if (r_state == S_CLEAR) begin
                r_clr_addr <= r_clr_addr + 13'd1;
            end
            if (w_swap_set) begin
                r_swap_pending <= 1'b1;
            end
            if (w_apply) begin
                r_swap_pending <= 1'b0;
                r_front_sel    <= ~r_front_sel;
                r_frame_count  <= r_frame_count + 8'd1;
            end
            if (w_wr_fire && !w_wr_in_range) begin
                r_wr_oor <= 1'b1;
            end
        end
    end

    // Writes always target the back buffer, the one not being displayed.
    always_ff @(posedge clk) begin
        if (w_we) begin
            if (r_front_sel) begin
                r_mem0[w_waddr] <= w_wdata;
            end else begin
                r_mem1[w_waddr] <= w_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pixel_data <= '0;
        end else if (bus.pixel_index >= c_DEPTH) begin
            r_pixel_data <= OOR_COLOUR;
        end else if (r_front_sel) begin
            r_pixel_data <= r_mem1[bus.pixel_index];
        end else begin
            r_pixel_data <= r_mem0[bus.pixel_index];
        end
    end

    assign bus.pixel_data   = r_pixel_data;
    assign bus.wr_ready     = w_wr_ready;
    assign bus.clr_busy     = (r_state == S_CLEAR);
    assign bus.swap_pending = r_swap_pending;
    assign bus.front_sel    = r_front_sel;
    assign bus.wr_oor       = r_wr_oor;
    assign bus.frame_count  = r_frame_count;

endmodule
`default_nettype wire

// File: doc/oled_frame_server.md
Name: oled_frame_server

Overview:
- Double-buffered 96x64 RGB565 frame store that answers the pixel requests issued by the Oled_Display driver (pixel_index in, pixel_data out).
- Game logic writes individual pixels or block-clears into the back buffer. A requested buffer swap takes effect only at the driver's frame_begin, so the panel never tears.
- Sits between a game module (maze, flow grid) and one Oled_Display instance, all on the driver's clock.

Parameters:
- WIDTH, 96, pixels per row; address = y*WIDTH + x.
- HEIGHT, 64, rows.
- OOR_COLOUR, 16'h0000, pixel_data returned for pixel_index >= WIDTH*HEIGHT.

Ports:
- clk  in  1  single clock (the same clock as the Oled_Display instance it serves).
- reset  in  1  synchronous, active-high.
- frame_begin  in  1  one-cycle pulse from the driver at frame start.
- sample_pixel  in  1  driver strobe; informational only, no state depends on it.
- pixel_index  in  13  driver read address.
- pixel_data  out  16  registered front-buffer word.
- wr_valid  in  1  pixel write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_x  in  7  write column.
- wr_y  in  6  write row.
- wr_colour  in  16  write data.
- clr_req  in  1  start a back-buffer fill.
- clr_colour  in  16  fill value, sampled on the accepted clr_req.
- clr_busy  out  1  fill in progress.
- swap_req  in  1  request a front/back exchange.
- swap_pending  out  1  swap latched, not yet applied.
- front_sel  out  1  index of the buffer currently displayed.
- wr_oor  out  1  sticky; set on any accepted write with x>=WIDTH or y>=HEIGHT.
- frame_count  out  8  wrapping count of applied swaps.

Behaviour:
- Reset values:
  - pixel_data=0, front_sel=0, swap_pending=0, clr_busy=0, wr_oor=0, frame_count=0.
  - wr_ready=1 in the first cycle after reset is released.
  - RAM contents are not reset.
- Read path:
  - pixel_data <= front[pixel_index] on every clk, latency exactly 1 cycle.
  - If pixel_index >= WIDTH*HEIGHT, pixel_data <= OOR_COLOUR.
  - The driver holds pixel_index for >=2 cycles before sampling.
- Write path:
  - wr_ready = !clr_busy && !swap_pending.
  - An accepted in-range write stores wr_colour at back[wr_y*WIDTH+wr_x], where back = !front_sel. It is visible at the next read of that address after the swap that exposes it.
  - An accepted out-of-range write is consumed with no RAM write and sets wr_oor. wr_oor clears only on reset.
- FSM states IDLE, CLEAR, WAIT_SWAP:
  - IDLE: clr_req -> CLEAR. clr_busy=1, addr counter=0, colour latched.
  - IDLE: swap_req (no clr_req) -> WAIT_SWAP, swap_pending=1.
  - IDLE: clr_req and swap_req in the same cycle -> CLEAR, and the swap is remembered in a flag.
  - CLEAR: write clr_colour to back[addr] every cycle, addr+1. On the cycle addr=WIDTH*HEIGHT-1 is written, clr_busy drops next cycle.
  - CLEAR completes (6144 cycles at defaults) -> WAIT_SWAP if a swap flag is set, else IDLE.
  - CLEAR: a swap_req arriving during CLEAR sets the swap flag and swap_pending=1 immediately. clr_req during CLEAR is ignored.
  - WAIT_SWAP: on a frame_begin pulse, front_sel toggles, frame_count+1 (wraps 255->0), swap_pending=0, -> IDLE.
  - WAIT_SWAP: a frame_begin in the same cycle that swap_req is first seen in IDLE does not apply it; the next pulse applies it.
  - WAIT_SWAP: clr_req and additional swap_req are ignored.
- front_sel changes only on the cycle after frame_begin. Reads that cycle still use the old front buffer; reads from the following cycle use the new front.
- Reset asserted mid-CLEAR or mid-WAIT_SWAP aborts: IDLE, partial fill left in RAM, swap discarded, front_sel=0.
- The swap does not copy data; after a swap the back buffer holds the previous front contents.

Test Plan:
- Reset, then clr_req with clr_colour=16'hF800 -> clr_busy high for 6144 cycles, wr_ready=0 throughout. Then swap_req, frame_begin pulse -> front_sel=1, frame_count=1, pixel_index=100 reads 16'hF800 one cycle later.
- Write x=95,y=63,colour=16'h07E0, swap at frame_begin -> pixel_index=6143 returns 16'h07E0. pixel_index=6144 returns OOR_COLOUR.
- Write x=96,y=0 -> accepted (wr_ready high), wr_oor=1, no RAM change at address 96 (row 1, col 0) or anywhere else.
- swap_req asserted in the same cycle as frame_begin -> front_sel unchanged. It toggles only after the next frame_begin; wr_ready=0 in between.
- clr_req+swap_req together, frame_begin pulses during the clear -> no toggle until the clear ends. The first frame_begin after the clear toggles front_sel.
- Reset at clear address 3000 -> clr_busy=0, swap_pending=0, front_sel=0 next cycle. Addresses 0..2999 hold the fill colour, 3000+ unchanged.
